// File: rtl/piso_pkg.sv
// Purpose: shared types and helpers for the piso_serial_tx transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: state_t FSM encoding, cnt_width() bit-counter width helper.
// Build option: PARITY is only reachable when PISO_PARITY_EN is defined.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Counter covers bit indices 0..width-1; floor at 1 bit so a width of 1
  // never yields a zero-width vector.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serial_tx_dff_srst.sv
// Purpose: single D flip-flop with synchronous active-low clear.
// Latency: 1 cycle from d to q.
// Backpressure: none; captures d on every rising edge.
// Ports: d (data in), clk (clock), rst (sync clear, active low), q (data out).
module dff_srst (
  input  logic d,
  input  logic clk,
  input  logic rst,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Purpose: parallel-in serial-out transmitter built from a dff_srst chain.
// Latency: first bit on q the cycle after accept; frame lasts WIDTH cycles
//          (WIDTH+1 with PISO_PARITY_EN), done pulses in the next cycle.
// Backpressure: load_ready is high only in IDLE; load_valid is ignored otherwise.
// Ports: clk, rst (sync active-low), din/load_valid/load_ready (word handshake),
//        q (serial bit), frame (q carries a valid bit), done (end-of-frame pulse).
// Build option: define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_serial_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             frame,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sr_shift;
  logic            fill_bit;
  logic            frame_d, done_d;
  logic            live_q;
  logic            accept;
  logic            last_bit;

  // live_q rises on the first edge that samples rst high, so load_ready
  // stays low throughout reset and a held load_valid cannot sneak in.
  dff_srst u_live (.d(1'b1), .clk(clk), .rst(rst), .q(live_q));

  assign load_ready = live_q && (state_q == IDLE);
  assign accept     = load_valid && load_ready;
  assign last_bit   = (cnt_q == CW'(WIDTH - 1));

  // q is the head of the shift chain itself, so it is registered and reads 0
  // whenever the chain has been emptied by shifting in zeros or by reset.
  assign q = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

`ifdef PISO_PARITY_EN
  // On the first shift the chain still holds the whole captured word, so its
  // XOR is injected as the fill bit; it reaches the head exactly one cycle
  // after the last data bit, which is the PARITY cycle.
  assign fill_bit = (state_q == SHIFT) && (cnt_q == '0) && (^sr_q);
`else
  assign fill_bit = 1'b0;
`endif

  generate
    if (LSB_FIRST) begin : g_lsb
      assign sr_shift = {fill_bit, sr_q[WIDTH-1:1]};
    end else begin : g_msb
      assign sr_shift = {sr_q[WIDTH-2:0], fill_bit};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    frame_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_d    = din;
          frame_d = 1'b1;
        end
      end
      SHIFT: begin
        sr_d = sr_shift;
        if (last_bit) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
          frame_d = 1'b1;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          frame_d = 1'b1;
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sr_d    = sr_shift;
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      dff_srst u_sr (.d(sr_d[i]), .clk(clk), .rst(rst), .q(sr_q[i]));
    end
  endgenerate

  dff_srst u_frame (.d(frame_d), .clk(clk), .rst(rst), .q(frame));
  dff_srst u_done  (.d(done_d),  .clk(clk), .rst(rst), .q(done));

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: MSB-first and LSB-first instances share
// clk/rst; each scenario task drives vectors and checks hand-computed values.
module tb_piso_serial_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din, din_l;
  logic       load_valid, valid_l;
  logic       load_ready, ready_l;
  logic       q, q_l;
  logic       frame, frame_l;
  logic       done, done_l;

  int errors = 0;
  int checks = 0;

  piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(load_ready), .q(q), .frame(frame), .done(done)
  );

  piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din_l), .load_valid(valid_l),
    .load_ready(ready_l), .q(q_l), .frame(frame_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; load_valid = 1'b1; din = 8'hA5; valid_l = 1'b1; din_l = 8'h01;
    repeat (3) tick;
    checks++;
    if ({q, frame, done, load_ready} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got q/frame/done/ready=%b want 0000", {q, frame, done, load_ready});
    end
    checks++;
    if ({q_l, frame_l, done_l, ready_l} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs_lsb: got %b want 0000", {q_l, frame_l, done_l, ready_l});
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({load_ready, frame, ready_l, frame_l} !== 4'b1010) begin
      errors++; $display("FAIL reset_release: got ready/frame/ready_l/frame_l=%b want 1010", {load_ready, frame, ready_l, frame_l});
    end
    load_valid = 1'b0; valid_l = 1'b0;
    tick;
    checks++;
    if ({frame, frame_l} !== 2'b00) begin
      errors++; $display("FAIL reset_no_accept: got frames=%b want 00", {frame, frame_l});
    end
  endtask

  task automatic test_msb_first;
    logic [7:0] seq;
    seq = 8'b1010_0101;
    din = 8'hA5; load_valid = 1'b1;
    tick;
    load_valid = 1'b0; din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q, frame, load_ready} !== {seq[7-i], 2'b10}) begin
        errors++; $display("FAIL msb_bit%0d: got q/frame/ready=%b want %b", i, {q, frame, load_ready}, {seq[7-i], 2'b10});
      end
      tick;
    end
`ifdef PISO_PARITY_EN
    checks++;
    if ({q, frame} !== 2'b01) begin
      errors++; $display("FAIL msb_parity: got q/frame=%b want 01", {q, frame});
    end
    tick;
`endif
    checks++;
    if ({frame, done, load_ready, q} !== 4'b0110) begin
      errors++; $display("FAIL msb_done: got frame/done/ready/q=%b want 0110", {frame, done, load_ready, q});
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL msb_done_clear: got done=%b want 0", done);
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] seq;
    seq = 8'b1000_0000;
    din_l = 8'h01; valid_l = 1'b1;
    tick;
    valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q_l, frame_l} !== {seq[7-i], 1'b1}) begin
        errors++; $display("FAIL lsb_bit%0d: got q/frame=%b want %b", i, {q_l, frame_l}, {seq[7-i], 1'b1});
      end
      tick;
    end
`ifdef PISO_PARITY_EN
    checks++;
    if ({q_l, frame_l} !== 2'b11) begin
      errors++; $display("FAIL lsb_parity: got q/frame=%b want 11", {q_l, frame_l});
    end
    tick;
`endif
    checks++;
    if ({frame_l, done_l} !== 2'b01) begin
      errors++; $display("FAIL lsb_done: got frame/done=%b want 01", {frame_l, done_l});
    end
    tick;
    checks++;
    if (done_l !== 1'b0) begin
      errors++; $display("FAIL lsb_done_clear: got done=%b want 0", done_l);
    end
  endtask

  task automatic test_back_to_back;
    din = 8'hFF; load_valid = 1'b1;
    tick;
    din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q, frame} !== 2'b11) begin
        errors++; $display("FAIL b2b_ones%0d: got q/frame=%b want 11", i, {q, frame});
      end
      tick;
    end
`ifdef PISO_PARITY_EN
    checks++;
    if ({q, frame} !== 2'b01) begin
      errors++; $display("FAIL b2b_parity_ff: got q/frame=%b want 01", {q, frame});
    end
    tick;
`endif
    checks++;
    if ({frame, done, load_ready} !== 3'b011) begin
      errors++; $display("FAIL b2b_gap: got frame/done/ready=%b want 011", {frame, done, load_ready});
    end
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q, frame, done} !== 3'b010) begin
        errors++; $display("FAIL b2b_zeros%0d: got q/frame/done=%b want 010", i, {q, frame, done});
      end
      tick;
    end
`ifdef PISO_PARITY_EN
    checks++;
    if ({q, frame} !== 2'b01) begin
      errors++; $display("FAIL b2b_parity_00: got q/frame=%b want 01", {q, frame});
    end
    tick;
`endif
    checks++;
    if ({frame, done} !== 2'b01) begin
      errors++; $display("FAIL b2b_done: got frame/done=%b want 01", {frame, done});
    end
    tick;
  endtask

  task automatic test_busy_ignore;
    logic [7:0] seq, seq2;
    seq  = 8'b1010_0101;
    seq2 = 8'b0011_1100;
    din = 8'hA5; load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q, frame, load_ready} !== {seq[7-i], 2'b10}) begin
        errors++; $display("FAIL busy_bit%0d: got q/frame/ready=%b want %b", i, {q, frame, load_ready}, {seq[7-i], 2'b10});
      end
      if (i == 2) begin
        din = 8'h3C; load_valid = 1'b1;
      end
      tick;
    end
`ifdef PISO_PARITY_EN
    checks++;
    if ({q, frame} !== 2'b01) begin
      errors++; $display("FAIL busy_parity: got q/frame=%b want 01", {q, frame});
    end
    tick;
`endif
    checks++;
    if ({frame, done, load_ready} !== 3'b011) begin
      errors++; $display("FAIL busy_done: got frame/done/ready=%b want 011", {frame, done, load_ready});
    end
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q, frame} !== {seq2[7-i], 1'b1}) begin
        errors++; $display("FAIL busy_3c_bit%0d: got q/frame=%b want %b", i, {q, frame}, {seq2[7-i], 1'b1});
      end
      tick;
    end
`ifdef PISO_PARITY_EN
    checks++;
    if ({q, frame} !== 2'b01) begin
      errors++; $display("FAIL busy_3c_parity: got q/frame=%b want 01", {q, frame});
    end
    tick;
`endif
    checks++;
    if ({frame, done} !== 2'b01) begin
      errors++; $display("FAIL busy_3c_done: got frame/done=%b want 01", {frame, done});
    end
    tick;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] seq, seq2;
    seq  = 8'b1010_0101;
    seq2 = 8'b0000_1111;
    din = 8'hA5; load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({q, frame} !== {seq[7-i], 1'b1}) begin
        errors++; $display("FAIL abort_bit%0d: got q/frame=%b want %b", i, {q, frame}, {seq[7-i], 1'b1});
      end
      tick;
    end
    rst = 1'b0;
    tick;
    checks++;
    if ({q, frame, done} !== 3'b000) begin
      errors++; $display("FAIL abort_outputs: got q/frame/done=%b want 000", {q, frame, done});
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({done, frame, load_ready} !== 3'b001) begin
      errors++; $display("FAIL abort_release: got done/frame/ready=%b want 001", {done, frame, load_ready});
    end
    din = 8'h0F; load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q, frame} !== {seq2[7-i], 1'b1}) begin
        errors++; $display("FAIL abort_0f_bit%0d: got q/frame=%b want %b", i, {q, frame}, {seq2[7-i], 1'b1});
      end
      tick;
    end
`ifdef PISO_PARITY_EN
    checks++;
    if ({q, frame} !== 2'b01) begin
      errors++; $display("FAIL abort_0f_parity: got q/frame=%b want 01", {q, frame});
    end
    tick;
`endif
    checks++;
    if ({frame, done} !== 2'b01) begin
      errors++; $display("FAIL abort_0f_done: got frame/done=%b want 01", {frame, done});
    end
    tick;
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity;
    logic [7:0] words [2];
    logic       pars  [2];
    words[0] = 8'h07; pars[0] = 1'b1;
    words[1] = 8'h03; pars[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      din = words[w]; load_valid = 1'b1;
      tick;
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if ({q, frame} !== {words[w][7-i], 1'b1}) begin
          errors++; $display("FAIL par%0d_bit%0d: got q/frame=%b want %b", w, i, {q, frame}, {words[w][7-i], 1'b1});
        end
        tick;
      end
      checks++;
      if ({q, frame, done} !== {pars[w], 2'b10}) begin
        errors++; $display("FAIL par%0d_parity: got q/frame/done=%b want %b", w, {q, frame, done}, {pars[w], 2'b10});
      end
      tick;
      checks++;
      if ({frame, done} !== 2'b01) begin
        errors++; $display("FAIL par%0d_done: got frame/done=%b want 01", w, {frame, done});
      end
      tick;
    end
  endtask
`endif

  initial begin
    rst = 1'b0; load_valid = 1'b0; valid_l = 1'b0; din = '0; din_l = '0;
    test_reset;
    test_msb_first;
    test_lsb_first;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid_frame;
`ifdef PISO_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
- Parallel-in, serial-out transmitter built from a chain of D flip-flops. It pairs with the serial-input flop chains in the flip-flops area.
- Accepts a WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per clk on q, with a frame strobe.
- Pulses done for one cycle when the frame ends.

Parameters:
- WIDTH, 8: data word width. Must be >= 2.
- LSB_FIRST, 0: 0 sends MSB first; 1 sends LSB first.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- din  in  WIDTH  parallel word; captured on handshake.
- load_valid  in  1  source has a word on din.
- load_ready  out  1  block can accept a word (high only in IDLE).
- q  out  1  serial data, registered.
- frame  out  1  high while q carries a valid bit, registered.
- done  out  1  one-cycle pulse in the first IDLE cycle after a frame.

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE; shift register and bit counter cleared.
  - q=0, frame=0, done=0.
  - load_ready reads 1 from the first edge where rst is sampled 1.
  - load_valid is ignored while rst==0.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the feature enabled).
- IDLE:
  - load_ready=1, frame=0, q=0.
  - On load_valid && load_ready at an edge: capture din, counter=0, go to SHIFT.
- SHIFT:
  - q = current bit (din[WIDTH-1-n] for MSB-first, din[n] for LSB-first); frame=1.
  - The counter advances each edge.
  - After bit WIDTH-1: go to PARITY if the feature is enabled, else to IDLE with done=1.
- Latency: first bit on q in the cycle after the accept edge. Frame length is exactly WIDTH cycles (WIDTH+1 with parity).
- Counter width: $clog2(WIDTH); wrap is never reached, because the exit happens at WIDTH-1.
- done=1 for exactly one cycle, the first IDLE cycle after a frame.
- A new accept is allowed in that same cycle, so the minimum inter-frame gap is 1 cycle with frame=0.
- load_valid during SHIFT or PARITY: not accepted (load_ready=0); din is not sampled and the frame in flight is unaffected.
- din changing after accept: no effect on the frame in flight.
- Reset mid-frame: at the next edge the frame is aborted; state=IDLE, q=0, frame=0, and no done pulse.
- Simultaneous rst==0 and handshake: reset wins; the word is dropped.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, one PARITY cycle drives q = XOR of all captured data bits (even parity), with frame=1.
  - Then IDLE with the done pulse; frame length is WIDTH+1.
- Undefined: no PARITY state and no parity logic; frame length is WIDTH.

Decomposition:
- Shared package piso_pkg:
  - state enum (IDLE, SHIFT, PARITY);
  - localparam function for the counter width ($clog2 wrapper).
- One natural sub-module, dff_srst: a 1-bit D flop with synchronous active-low clear, ports (d, clk, rst, q).
  - It is instantiated WIDTH times for the shift chain; the q/frame/done output registers also use it.

Test Plan (WIDTH=8 unless noted):
- MSB-first, accept din=8'hA5:
  - cycles 1..8 after accept give q=1,0,1,0,0,1,0,1 with frame=1;
  - cycle 9 gives frame=0, done=1; cycle 10 gives done=0.
- LSB_FIRST=1, din=8'h01: q=1 then seven 0s, frame high for 8 cycles, done pulse on cycle 9.
- load_valid held high with 8'hFF, then 8'h00:
  - the second word is accepted on the done cycle;
  - exactly one frame=0 cycle separates 8 ones and 8 zeros.
- load_valid=1, din=8'h3C raised mid-frame (during the 8'hA5 frame):
  - load_ready=0 and the 8'hA5 sequence is unchanged;
  - 8'h3C is accepted only at the following IDLE edge.
- rst=0 asserted at bit 4 of 8'hA5:
  - next edge gives q=0, frame=0, and no done pulse;
  - after rst=1, load_ready=1 and a new 8'h0F frame sends 0,0,0,0,1,1,1,1.
- PISO_PARITY_EN, din=8'h07:
  - 8 data bits, then q=1 (parity) on cycle 9 with frame=1;
  - done on cycle 10. With din=8'h03, the parity bit is 0.
